bec_wb_loader: RTL

//  Wishbone slave that stages operand words and a scalar key for the bec core,

---
 rtl/bec_loader_pkg.sv | 33 +++
 rtl/bec_word_fifo.sv | 60 ++++++
 rtl/bec_wb_loader.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/bec_loader_pkg.sv
// Shared definitions for the bec Wishbone loader: FSM states, register map
// and STATUS bit positions.
package bec_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_WAIT_LD = 3'd2,
        ST_RUN     = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    localparam logic [7:0] REG_CTRL   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h04;
    localparam logic [7:0] REG_LOAD   = 8'h08;
    localparam logic [7:0] REG_KEY    = 8'h0C;
    localparam logic [7:0] REG_RESULT = 8'h10;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;

    localparam int SB_FULL  = 3;
    localparam int SB_EMPTY = 4;
    localparam int SB_RESV  = 5;
    localparam int SB_OVF   = 6;
    localparam int SB_UDF   = 7;

    function automatic int key_words(input int bits);
        return (bits + 31) / 32;
    endfunction

endpackage

// File: rtl/bec_word_fifo.sv
// Synchronous word FIFO with flush; depth need not be a power of two.
module bec_word_fifo #(
    parameter int DEPTH = 6,
    parameter int WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is still accepted when a pop frees a slot that cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/bec_wb_loader.sv
// Wishbone slave that stages operands and key for the bec core, sequences it
// through load/run/capture and buffers the results for firmware.
module bec_wb_loader
    import bec_loader_pkg::*;
#(
    parameter int          NWORDS   = 6,
    parameter int          KEY_BITS = 163,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        bec_enable_o,
    output logic        bec_load_data_o,
    output logic [31:0] bec_data_o,
    input  logic [5:0]  bec_load_status_i,
    output logic        bec_ki_o,
    input  logic        bec_next_key_i,
    input  logic [3:0]  bec_status_i,
    input  logic [31:0] bec_data_i,
    input  logic        bec_done_i,
    output logic        irq_o
);

    localparam int KEY_W = key_words(KEY_BITS) * 32;
    localparam int IDX_W = $clog2(KEY_W);
    localparam int RP_W  = $clog2(NWORDS + 1);

    state_e           state_q;
    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;
    logic             ovf_q, udf_q;
    logic [KEY_W-1:0] key_q;
    logic [IDX_W-1:0] key_idx_q;
    logic [5:0]       words_q;
    logic [RP_W-1:0]  cap_q;
    logic [RP_W-1:0]  res_rd_q;
    logic [31:0]      res_q [NWORDS];
    logic             res_valid_q;
    logic             enable_q, load_q, irq_q;
    logic [31:0]      bec_data_q;

    logic            hit, wr_hit, rd_hit;
    logic [7:0]      ofs;
    logic            start_req, abort_req, rd_result, ovf_set, udf_set;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [31:0]     fifo_rdata;
    logic [RP_W-1:0] fifo_count;
    logic [31:0]     status_w;
    logic            unused_sel;

    assign unused_sel = ^wbs_sel_i;

    // The ~ack_q term keeps a held strobe from producing back-to-back acks.
    assign hit    = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADR[31:8]) & ~ack_q;
    assign wr_hit = hit & wbs_we_i;
    assign rd_hit = hit & ~wbs_we_i;
    assign ofs    = wbs_adr_i[7:0];
    assign ack_d  = hit;

    assign start_req = wr_hit & (ofs == REG_CTRL) & wbs_dat_i[CTRL_START];
    assign abort_req = wr_hit & (ofs == REG_CTRL) & wbs_dat_i[CTRL_ABORT];
    assign fifo_push = wr_hit & (ofs == REG_LOAD);
    assign fifo_pop  = (state_q == ST_LOAD);
    assign rd_result = rd_hit & (ofs == REG_RESULT);
    assign ovf_set   = fifo_push & fifo_full & ~fifo_pop;
    assign udf_set   = rd_result & ~res_valid_q;

    bec_word_fifo #(.DEPTH(NWORDS), .WIDTH(32)) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_n_i (wb_rst_n_i),
        .flush_i (abort_req),
        .push_i  (fifo_push),
        .wdata_i (wbs_dat_i),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        status_w           = '0;
        status_w[2:0]      = state_q;
        status_w[SB_FULL]  = fifo_full;
        status_w[SB_EMPTY] = fifo_empty;
        status_w[SB_RESV]  = res_valid_q;
        status_w[SB_OVF]   = ovf_q;
        status_w[SB_UDF]   = udf_q;
        status_w[11:8]     = bec_status_i;
    end

    always_comb begin
        dat_d = '0;
        if (rd_hit) begin
            case (ofs)
                REG_STATUS: dat_d = status_w;
                REG_RESULT: if (res_valid_q) dat_d = res_q[res_rd_q];
                default:    dat_d = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
            key_q <= '0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
            if (wr_hit && ofs == REG_STATUS && wbs_dat_i[SB_OVF]) ovf_q <= 1'b0;
            else if (ovf_set) ovf_q <= 1'b1;
            if (wr_hit && ofs == REG_STATUS && wbs_dat_i[SB_UDF]) udf_q <= 1'b0;
            else if (udf_set) udf_q <= 1'b1;
            if (wr_hit && ofs == REG_KEY && state_q == ST_IDLE)
                key_q <= {key_q[KEY_W-33:0], wbs_dat_i};
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= ST_IDLE;
            key_idx_q   <= '0;
            words_q     <= '0;
            cap_q       <= '0;
            res_rd_q    <= '0;
            res_valid_q <= 1'b0;
            enable_q    <= 1'b0;
            load_q      <= 1'b0;
            irq_q       <= 1'b0;
            bec_data_q  <= '0;
            for (int i = 0; i < NWORDS; i++) res_q[i] <= '0;
        end else begin
            load_q <= 1'b0;
            if (abort_req) begin
                state_q     <= ST_IDLE;
                enable_q    <= 1'b0;
                words_q     <= '0;
                res_rd_q    <= '0;
                res_valid_q <= 1'b0;
                irq_q       <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_req && fifo_count == RP_W'(NWORDS)) begin
                            words_q <= '0;
                            state_q <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        bec_data_q <= fifo_rdata;
                        load_q     <= 1'b1;
                        words_q    <= words_q + 6'd1;
                        state_q    <= ST_WAIT_LD;
                    end
                    ST_WAIT_LD: begin
                        if (bec_load_status_i == words_q) begin
                            if (words_q == 6'(NWORDS)) begin
                                key_idx_q <= IDX_W'(KEY_BITS - 1);
                                enable_q  <= 1'b1;
                                state_q   <= ST_RUN;
                            end else begin
                                state_q <= ST_LOAD;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (bec_done_i) begin
                            res_q[0] <= bec_data_i;
                            cap_q    <= RP_W'(1);
                            enable_q <= 1'b0;
                            state_q  <= ST_CAPTURE;
                        end else if (bec_next_key_i && key_idx_q != '0) begin
                            key_idx_q <= key_idx_q - 1'b1;
                        end
                    end
                    ST_CAPTURE: begin
                        res_q[cap_q] <= bec_data_i;
                        cap_q        <= cap_q + 1'b1;
                        if (cap_q == RP_W'(NWORDS - 1)) begin
                            res_rd_q    <= '0;
                            res_valid_q <= 1'b1;
                            irq_q       <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (rd_result) begin
                            if (res_rd_q == RP_W'(NWORDS - 1)) begin
                                res_rd_q    <= '0;
                                res_valid_q <= 1'b0;
                                irq_q       <= 1'b0;
                                state_q     <= ST_IDLE;
                            end else begin
                                res_rd_q <= res_rd_q + 1'b1;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign wbs_ack_o       = ack_q;
    assign wbs_dat_o       = dat_q;
    assign bec_enable_o    = enable_q;
    assign bec_load_data_o = load_q;
    assign bec_data_o      = bec_data_q;
    assign bec_ki_o        = (state_q == ST_RUN) ? key_q[key_idx_q] : 1'b0;
    assign irq_o           = irq_q;

endmodule
